// File: rtl/core_bus_pkg.sv
`default_nettype none
// ============================================================================
// core_bus_pkg : shared FSM/route types and index-width helper for the bridge
// Rev 1.0
// ============================================================================
package core_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_e;

  typedef enum logic {
    ROUTE_MAIN = 1'b0,
    ROUTE_DMEM = 1'b1
  } route_e;

  // A single requester still needs a 1-bit index so vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : N-way round-robin, first requester at or after ptr_i wins
// Rev 1.0
// ============================================================================
module rr_arbiter
  import core_bus_pkg::*;
#(
  parameter int  N_PORTS = 2,
  localparam int IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [N_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    sum     = 0;
    cand    = '0;
    for (int off = 0; off < N_PORTS; off++) begin
      sum = int'(ptr_i) + off;
      if (sum >= N_PORTS) begin
        sum = sum - N_PORTS;
      end
      cand = IDX_W'(sum);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    valid_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/core_wb_bus_bridge.sv
`default_nettype none
// ============================================================================
// core_wb_bus_bridge : N-requester to Wishbone bridge, one outstanding access,
// optional second-memory window and per-access timeout.  Rev 1.0
// ============================================================================
module core_wb_bus_bridge
  import core_bus_pkg::*;
#(
  parameter int                N_PORTS        = 2,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                SECOND_MEM_EN  = 0,
  parameter logic [ADDR_W-1:0] DMEM_BASE      = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] DMEM_MASK      = 32'hF000_0000,
  parameter int                TIMEOUT_CYCLES = 1024,
  localparam int               STRB_W         = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req_valid_i,
  input  logic [N_PORTS-1:0]          req_we_i,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata_i,
  input  logic [N_PORTS*STRB_W-1:0]   req_wstrb_i,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic [N_PORTS-1:0]          rsp_ack_o,
  output logic [N_PORTS-1:0]          rsp_err_o,
  output logic                        core_cyc,
  output logic                        core_stb,
  output logic                        core_we,
  output logic [STRB_W-1:0]           core_wstrb,
  output logic [ADDR_W-1:0]           core_addr,
  output logic [DATA_W-1:0]           core_data_out,
  input  logic [DATA_W-1:0]           core_data_in,
  input  logic                        core_ack,
  output logic                        data_mem_cyc,
  output logic                        data_mem_stb,
  output logic                        data_mem_we,
  output logic [STRB_W-1:0]           data_mem_wstrb,
  output logic [ADDR_W-1:0]           data_mem_addr,
  output logic [DATA_W-1:0]           data_mem_data_out,
  input  logic [DATA_W-1:0]           data_mem_data_in,
  input  logic                        data_mem_ack
);

  localparam int               IDX_W    = idx_width(N_PORTS);
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PORTS - 1);

  bridge_state_e       state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_PORTS-1:0]  grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  route_e              route_q, route_d;
  logic                cyc_q, cyc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_PORTS-1:0]  rsp_ack_q, rsp_ack_d;
  logic [N_PORTS-1:0]  rsp_err_q, rsp_err_d;

  logic                arb_valid;
  logic [N_PORTS-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                main_sel;
  logic                dmem_sel;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;

  rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign main_sel = (route_q == ROUTE_MAIN);

  if (SECOND_MEM_EN != 0) begin : g_dmem
    assign dmem_sel = (route_q == ROUTE_DMEM);
  end else begin : g_no_dmem
    assign dmem_sel = 1'b0;
  end

  assign sel_ack   = main_sel ? core_ack     : data_mem_ack;
  assign sel_rdata = main_sel ? core_data_in : data_mem_data_in;
  assign gnt_addr  = req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    route_d   = route_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rsp_ack_d = '0;
    rsp_err_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d   = arb_idx;
          grant_d = arb_grant;
          we_d    = req_we_i[arb_idx];
          addr_d  = gnt_addr;
          wdata_d = req_wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
          wstrb_d = req_wstrb_i[int'(arb_idx)*STRB_W +: STRB_W];
          route_d = ((SECOND_MEM_EN != 0) && ((gnt_addr & DMEM_MASK) == DMEM_BASE))
                    ? ROUTE_DMEM : ROUTE_MAIN;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (sel_ack) begin
          cyc_d     = 1'b0;
          rdata_d   = we_q ? '0 : sel_rdata;
          rsp_ack_d = grant_q;
          state_d   = ST_RESP;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == TMO_LAST)) begin
          cyc_d     = 1'b0;
          rdata_d   = '0;
          rsp_err_d = grant_q;
          state_d   = ST_RESP;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      route_q   <= ROUTE_MAIN;
      cyc_q     <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rsp_ack_q <= '0;
      rsp_err_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      route_q   <= route_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rsp_ack_q <= rsp_ack_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_ack_o   = rsp_ack_q;
  assign rsp_err_o   = rsp_err_q;

  assign core_cyc          = cyc_q & main_sel;
  assign core_stb          = cyc_q & main_sel;
  assign core_we           = we_q & main_sel;
  assign core_wstrb        = main_sel ? wstrb_q : '0;
  assign core_addr         = main_sel ? addr_q  : '0;
  assign core_data_out     = main_sel ? wdata_q : '0;

  assign data_mem_cyc      = cyc_q & dmem_sel;
  assign data_mem_stb      = cyc_q & dmem_sel;
  assign data_mem_we       = we_q & dmem_sel;
  assign data_mem_wstrb    = dmem_sel ? wstrb_q : '0;
  assign data_mem_addr     = dmem_sel ? addr_q  : '0;
  assign data_mem_data_out = dmem_sel ? wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_wb_bus_bridge.sv
`default_nettype none
// ============================================================================
// tb_core_wb_bus_bridge : self-checking bench for core_wb_bus_bridge
// Rev 1.0
// ============================================================================
module tb_core_wb_bus_bridge;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid_i, req_we_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N*SW-1:0]   req_wstrb_i;
  logic [DW-1:0]     rsp_rdata_o;
  logic [N-1:0]      rsp_ack_o, rsp_err_o;
  logic              core_cyc, core_stb, core_we, core_ack;
  logic [SW-1:0]     core_wstrb;
  logic [AW-1:0]     core_addr;
  logic [DW-1:0]     core_data_out, core_data_in;
  logic              data_mem_cyc, data_mem_stb, data_mem_we, data_mem_ack;
  logic [SW-1:0]     data_mem_wstrb;
  logic [AW-1:0]     data_mem_addr;
  logic [DW-1:0]     data_mem_data_out, data_mem_data_in;

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;
  bit stray_en = 1'b0;

  logic          m_we    [N];
  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];
  logic [SW-1:0] m_strb  [N];

  core_wb_bus_bridge #(
    .N_PORTS        (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .SECOND_MEM_EN  (1),
    .DMEM_BASE      (32'h8000_0000),
    .DMEM_MASK      (32'hF000_0000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_we_i          (req_we_i),
    .req_addr_i        (req_addr_i),
    .req_wdata_i       (req_wdata_i),
    .req_wstrb_i       (req_wstrb_i),
    .rsp_rdata_o       (rsp_rdata_o),
    .rsp_ack_o         (rsp_ack_o),
    .rsp_err_o         (rsp_err_o),
    .core_cyc          (core_cyc),
    .core_stb          (core_stb),
    .core_we           (core_we),
    .core_wstrb        (core_wstrb),
    .core_addr         (core_addr),
    .core_data_out     (core_data_out),
    .core_data_in      (core_data_in),
    .core_ack          (core_ack),
    .data_mem_cyc      (data_mem_cyc),
    .data_mem_stb      (data_mem_stb),
    .data_mem_we       (data_mem_we),
    .data_mem_wstrb    (data_mem_wstrb),
    .data_mem_addr     (data_mem_addr),
    .data_mem_data_out (data_mem_data_out),
    .data_mem_data_in  (data_mem_data_in),
    .data_mem_ack      (data_mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int model_grant(input logic [N-1:0] mask);
    for (int off = 0; off < N; off++) begin
      if (mask[(exp_ptr + off) % N]) return (exp_ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic int model_bus(input logic [AW-1:0] a);
    return ((a & 32'hF000_0000) == 32'h8000_0000) ? 1 : 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_we[p] = we; m_addr[p] = a; m_wdata[p] = d; m_strb[p] = s;
  endtask

  task automatic apply_reqs(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]              = mask[i];
      req_we_i[i]                 = m_we[i];
      req_addr_i[i*AW +: AW]      = m_addr[i];
      req_wdata_i[i*DW +: DW]     = m_wdata[i];
      req_wstrb_i[i*SW +: SW]     = m_strb[i];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid_i = '0; req_we_i = '0; req_addr_i = '0;
    req_wdata_i = '0; req_wstrb_i = '0; core_ack = 1'b0; data_mem_ack = 1'b0;
    core_data_in = '0; data_mem_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  // Acts as both memories for one access: acks the bus carrying stb after lat
  // wait cycles (lat<0: never) and records what the bridge presented.
  task automatic run_one(input int lat, input logic [DW-1:0] mem, input bit drop_on_stb,
                         output int stb_n, output int bus, output logic [AW-1:0] b_addr,
                         output logic [DW-1:0] b_wdata, output logic [SW-1:0] b_strb,
                         output logic b_we, output logic [N-1:0] ack_v,
                         output logic [N-1:0] err_v, output logic [DW-1:0] rdata,
                         output int delay);
    bit done;
    int cur;
    logic [1+SW+AW+DW-1:0] obs;
    done = 1'b0; stb_n = 0; bus = -1; b_addr = '0; b_wdata = '0; b_strb = '0;
    b_we = 1'b0; ack_v = '0; err_v = '0; rdata = '0; delay = -1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if ((rsp_ack_o | rsp_err_o) != '0) begin
        ack_v = rsp_ack_o; err_v = rsp_err_o; rdata = rsp_rdata_o; delay = c; done = 1'b1;
        if (stray_en) core_ack = 1'b1;
      end else if (core_stb || data_mem_stb) begin
        cur = (core_stb && data_mem_stb) ? 3 : (data_mem_stb ? 1 : 0);
        if ((core_stb && !core_cyc) || (data_mem_stb && !data_mem_cyc)) cur = 3;
        obs = (cur == 1) ? {data_mem_we, data_mem_wstrb, data_mem_addr, data_mem_data_out}
                         : {core_we, core_wstrb, core_addr, core_data_out};
        if (stb_n == 0) begin
          {b_we, b_strb, b_addr, b_wdata} = obs;
          bus = cur;
        end else if (obs !== {b_we, b_strb, b_addr, b_wdata} || cur != bus) begin
          bus = 3;
        end
        stb_n++;
        if (stray_en) begin
          if (cur == 1) core_ack = 1'($urandom_range(0, 1));
          else          data_mem_ack = 1'($urandom_range(0, 1));
        end
        if (stb_n == lat + 1) begin
          if (cur == 1) begin data_mem_ack = 1'b1; data_mem_data_in = mem; end
          else          begin core_ack = 1'b1;     core_data_in = mem;     end
        end
        if (drop_on_stb) req_valid_i = '0;
      end
      @(posedge clk);
      #1;
      core_ack = 1'b0; data_mem_ack = 1'b0;
      core_data_in = $urandom; data_mem_data_in = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out} !== '0) begin
      errors++; $display("FAIL reset_core: got %h want 0",
        {core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out});
    end
    checks++;
    if ({data_mem_cyc, data_mem_stb, data_mem_we, data_mem_wstrb, data_mem_addr,
         data_mem_data_out} !== '0) begin
      errors++; $display("FAIL reset_dmem: got %h want 0", {data_mem_cyc, data_mem_stb,
        data_mem_we, data_mem_wstrb, data_mem_addr, data_mem_data_out});
    end
    checks++;
    if ({rsp_ack_o, rsp_err_o, rsp_rdata_o} !== '0) begin
      errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_ack_o, rsp_err_o, rsp_rdata_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int stb_n, bus, delay, g;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev, prev;
    prev = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0000_0100 + 32'(i*4), '0, '1);
    apply_reqs(2'b11);
    for (int t = 0; t < 4; t++) begin
      g = model_grant(2'b11);
      run_one($urandom_range(0, 2), 32'hC0DE_0000 + 32'(t), 1'b0,
              stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
      checks++;
      if (av !== N'(1 << g) || ev !== '0) begin
        errors++; $display("FAIL contention_grant t=%0d: ack=%b err=%b want ack=%b", t, av, ev, N'(1 << g));
      end
      checks++;
      if (av === prev) begin
        errors++; $display("FAIL contention_repeat t=%0d: ack=%b same as previous", t, av);
      end
      checks++;
      if (ba !== m_addr[g]) begin
        errors++; $display("FAIL contention_addr t=%0d: got %h want %h", t, ba, m_addr[g]);
      end
      prev = av;
      exp_ptr = (g + 1) % N;
    end
    req_valid_i = '0;
  endtask

  task automatic test_single_read();
    int stb_n, bus, delay;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev;
    set_req(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    apply_reqs(2'b10);
    run_one(0, 32'hDEAD_BEEF, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0;
    exp_ptr = 0;
    checks++;
    if (stb_n != 1 || bus != 0 || ba !== 32'h0000_0010) begin
      errors++; $display("FAIL single_bus: stb=%0d bus=%0d addr=%h want 1/0/00000010", stb_n, bus, ba);
    end
    checks++;
    if (delay != 2 || av !== 2'b10 || ev !== 2'b00) begin
      errors++; $display("FAIL single_rsp: delay=%0d ack=%b err=%b want 2/10/00", delay, av, ev);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_rdata: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_routing();
    int stb_n, bus, delay;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev;
    set_req(0, 1'b1, 32'h8000_0004, 32'hA5A5_1234, 4'b0011);
    apply_reqs(2'b01);
    run_one(1, 32'hFFFF_FFFF, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0; exp_ptr = 1;
    checks++;
    if (bus != 1 || {bw, bs, ba, bd} !== {1'b1, 4'b0011, 32'h8000_0004, 32'hA5A5_1234}) begin
      errors++; $display("FAIL route_dmem: bus=%0d we=%b strb=%b addr=%h data=%h want 1/1/0011/80000004/a5a51234",
                         bus, bw, bs, ba, bd);
    end
    checks++;
    if (av !== 2'b01 || rd !== '0 || delay != 3) begin
      errors++; $display("FAIL route_dmem_rsp: ack=%b rdata=%h delay=%0d want 01/0/3", av, rd, delay);
    end
    set_req(1, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 4'b1100);
    apply_reqs(2'b10);
    run_one(0, 32'h1111_1111, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0; exp_ptr = 0;
    checks++;
    if (bus != 0 || {bw, bs, ba, bd} !== {1'b1, 4'b1100, 32'h0000_0004, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL route_main: bus=%0d we=%b strb=%b addr=%h data=%h want 0/1/1100/00000004/0badf00d",
                         bus, bw, bs, ba, bd);
    end
  endtask

  task automatic test_timeout();
    int stb_n, bus, delay;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev;
    set_req(0, 1'b0, 32'h0000_0040, '0, 4'hF);
    apply_reqs(2'b01);
    run_one(1, 32'h5555_AAAA, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0; exp_ptr = 1;
    set_req(1, 1'b0, 32'h0000_0080, '0, 4'hF);
    apply_reqs(2'b10);
    run_one(-1, 32'h0, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0; exp_ptr = 0;
    checks++;
    if (stb_n != TMO || delay != TMO + 1) begin
      errors++; $display("FAIL timeout_len: stb=%0d delay=%0d want %0d/%0d", stb_n, delay, TMO, TMO + 1);
    end
    checks++;
    if (ev !== 2'b10 || av !== 2'b00 || rd !== '0) begin
      errors++; $display("FAIL timeout_rsp: err=%b ack=%b rdata=%h want 10/00/0", ev, av, rd);
    end
    apply_reqs(2'b01);
    run_one(1, 32'h1234_5678, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0; exp_ptr = 1;
    checks++;
    if (av !== 2'b01 || ev !== 2'b00 || rd !== 32'h1234_5678 || delay != 3) begin
      errors++; $display("FAIL after_timeout: ack=%b err=%b rdata=%h delay=%0d want 01/00/12345678/3",
                         av, ev, rd, delay);
    end
  endtask

  task automatic test_ack_at_timeout();
    int stb_n, bus, delay;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev;
    set_req(1, 1'b0, 32'h8000_0100, '0, 4'hF);
    apply_reqs(2'b10);
    run_one(TMO - 1, 32'h7777_0001, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0; exp_ptr = 0;
    checks++;
    if (av !== 2'b10 || ev !== 2'b00 || rd !== 32'h7777_0001 || stb_n != TMO || bus != 1) begin
      errors++; $display("FAIL ack_at_timeout: ack=%b err=%b rdata=%h stb=%0d bus=%0d want 10/00/77770001/%0d/1",
                         av, ev, rd, stb_n, bus, TMO);
    end
  endtask

  task automatic test_drop_after_grant();
    int stb_n, bus, delay;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev;
    set_req(0, 1'b0, 32'h0000_0200, '0, 4'hF);
    apply_reqs(2'b01);
    run_one(2, 32'h0D0D_0D0D, 1'b1, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    exp_ptr = 1;
    checks++;
    if (av !== 2'b01 || rd !== 32'h0D0D_0D0D || stb_n != 3 || delay != 4) begin
      errors++; $display("FAIL drop_after_grant: ack=%b rdata=%h stb=%0d delay=%0d want 01/0d0d0d0d/3/4",
                         av, rd, stb_n, delay);
    end
  endtask

  task automatic test_random();
    int stb_n, bus, delay, g, lat, exp_stb;
    bit exp_err;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd, mem, exp_rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev, mask, vec;
    stray_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom));
        if ($urandom_range(0, 1) == 1) m_addr[i][31:28] = 4'h8;
      end
      lat = $urandom_range(0, 9);
      if (lat == 9) lat = -1;
      mem = $urandom;
      g = model_grant(mask);
      vec = N'(1 << g);
      exp_err = (lat < 0) || (lat >= TMO);
      exp_stb = exp_err ? TMO : lat + 1;
      exp_rd = (exp_err || m_we[g]) ? '0 : mem;
      apply_reqs(mask);
      run_one(lat, mem, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
      req_valid_i = '0;
      exp_ptr = (g + 1) % N;
      checks++;
      if (av !== (exp_err ? '0 : vec) || ev !== (exp_err ? vec : '0)) begin
        errors++; $display("FAIL rand_rsp it=%0d: ack=%b err=%b want ack=%b err=%b", it, av, ev,
                           exp_err ? '0 : vec, exp_err ? vec : '0);
      end
      checks++;
      if (rd !== exp_rd || delay != exp_stb + 1 || stb_n != exp_stb) begin
        errors++; $display("FAIL rand_timing it=%0d: rdata=%h delay=%0d stb=%0d want %h/%0d/%0d",
                           it, rd, delay, stb_n, exp_rd, exp_stb + 1, exp_stb);
      end
      checks++;
      if (bus != model_bus(m_addr[g]) || {bw, bs, ba} !== {m_we[g], m_strb[g], m_addr[g]} ||
          (m_we[g] && bd !== m_wdata[g])) begin
        errors++; $display("FAIL rand_bus it=%0d: bus=%0d we=%b strb=%h addr=%h data=%h want %0d/%b/%h/%h/%h",
                           it, bus, bw, bs, ba, bd, model_bus(m_addr[g]), m_we[g], m_strb[g], m_addr[g], m_wdata[g]);
      end
    end
    stray_en = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int stb_n, bus, delay, seen, bad;
    logic [AW-1:0] ba; logic [DW-1:0] bd, rd; logic [SW-1:0] bs; logic bw;
    logic [N-1:0] av, ev;
    set_req(0, 1'b0, 32'h0000_0300, '0, 4'hF);
    apply_reqs(2'b01);
    run_one(0, 32'h9999_0000, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0;
    set_req(1, 1'b0, 32'h0000_0304, '0, 4'hF);
    apply_reqs(2'b10);
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      @(negedge clk);
      if (core_stb) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 3) begin
      errors++; $display("FAIL mid_busy_setup: stb cycles seen=%0d want 3", seen);
    end
    rst_n = 1'b0; req_valid_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ptr = 0;
    @(negedge clk);
    checks++;
    if ({core_cyc, core_stb, data_mem_cyc, data_mem_stb, rsp_ack_o, rsp_err_o} !== '0 || rsp_rdata_o !== '0) begin
      errors++; $display("FAIL mid_busy_reset: cyc/stb/rsp=%b rdata=%h want 0",
        {core_cyc, core_stb, data_mem_cyc, data_mem_stb, rsp_ack_o, rsp_err_o}, rsp_rdata_o);
    end
    @(posedge clk); #1;
    bad = 0;
    core_ack = 1'b1; core_data_in = 32'hBAD0_BAD0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if ({core_cyc, core_stb, rsp_ack_o, rsp_err_o} !== '0) bad++;
      @(posedge clk); #1;
      core_ack = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stray_ack: activity cycles=%0d want 0", bad);
    end
    set_req(0, 1'b0, 32'h0000_0400, '0, 4'hF);
    set_req(1, 1'b0, 32'h0000_0404, '0, 4'hF);
    apply_reqs(2'b11);
    run_one(0, 32'h4242_4242, 1'b0, stb_n, bus, ba, bd, bs, bw, av, ev, rd, delay);
    req_valid_i = '0;
    checks++;
    if (av !== 2'b01 || ba !== 32'h0000_0400 || rd !== 32'h4242_4242) begin
      errors++; $display("FAIL ptr_after_reset: ack=%b addr=%h rdata=%h want 01/00000400/42424242", av, ba, rd);
    end
    exp_ptr = 1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
    do_reset();
    test_reset();
    test_contention();
    test_single_read();
    test_routing();
    test_timeout();
    test_ack_at_timeout();
    test_drop_after_grant();
    test_random();
    test_reset_mid_busy();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_wb_bus_bridge.md
Name: core_wb_bus_bridge

Overview:
Parametrised N-requester to Wishbone bridge between a core's native request/response buses (port 0 = instruction, port 1 = data, extra ports for accelerators/debug) and the Controller's memory ports.
- Round-robin arbitration, one outstanding transaction.
- Optional address-window routing to a second memory port.
- Per-transaction timeout that returns an error instead of hanging the core.

Parameters:
N_PORTS, 2, number of requester ports (>=1)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8
SECOND_MEM_EN, 0, 1 = enable data_mem_* port and window routing
DMEM_BASE, 32'h8000_0000, second-memory window base
DMEM_MASK, 32'hF000_0000, window hit when (addr & DMEM_MASK) == DMEM_BASE
TIMEOUT_CYCLES, 1024, cycles without ack before error; 0 = timeout disabled

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous, active-low reset
req_valid_i  in  N_PORTS  per-port request, level-held until ack/err
req_we_i  in  N_PORTS  1 = write
req_addr_i  in  N_PORTS*ADDR_W  flattened addresses, port i at [i*ADDR_W +: ADDR_W]
req_wdata_i  in  N_PORTS*DATA_W  flattened write data
req_wstrb_i  in  N_PORTS*STRB_W  flattened byte strobes
rsp_rdata_o  out  DATA_W  read data, valid with rsp_ack_o/rsp_err_o
rsp_ack_o  out  N_PORTS  one-hot, one-cycle completion pulse
rsp_err_o  out  N_PORTS  one-hot, one-cycle timeout pulse
core_cyc, core_stb, core_we  out  1  Wishbone main port
core_wstrb  out  STRB_W
core_addr  out  ADDR_W
core_data_out  out  DATA_W
core_data_in  in  DATA_W
core_ack  in  1
data_mem_cyc, data_mem_stb, data_mem_we, data_mem_wstrb, data_mem_addr, data_mem_data_out, data_mem_data_in, data_mem_ack: same widths and directions as the core_* ports; present always, tied inactive when SECOND_MEM_EN=0.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM=IDLE, RR pointer=0, timeout counter=0. Takes effect the next edge even mid-transaction; no ack/err is generated for the aborted access.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - Samples req_valid_i. Grants the first requesting port at or after the RR pointer, wrapping at N_PORTS.
  - Latches we/addr/wdata/wstrb of the granted port and the route select (window hit && SECOND_MEM_EN).
  - Moves to BUSY. cyc/stb of the selected port are registered, so they rise the cycle after the request is seen.
- BUSY:
  - cyc=stb=1 on the selected port only; addr/data/we/wstrb come from the latched values and are stable.
  - On the selected ack: capture data_in (0 for writes), drop cyc/stb next edge, go to RESP.
  - The timeout counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES with no ack: drop cyc/stb, set rdata=0, flag err, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - Exactly one cycle: rsp_ack_o[g] or rsp_err_o[g] = 1, with rsp_rdata_o valid.
  - RR pointer becomes (g+1) mod N_PORTS, counter clears, FSM returns to IDLE.
- Minimum cost per transaction: 3 cycles plus memory latency. Zero-wait ack gives request at t, stb at t+1, ack at t+1, rsp_ack at t+2.
- Ack on the non-selected port, or any ack in IDLE/RESP, is ignored.
- A requester dropping req_valid after grant does not cancel the bus cycle; its response is still pulsed.
- Requests are sampled only in IDLE. A request withdrawn before grant is never issued.
- rsp_rdata_o holds its last value outside RESP.
- With N_PORTS=1 the pointer is constant 0 (index width max(1,$clog2(N_PORTS))).

Decomposition:
- Package core_bus_pkg: FSM state enum, index-width function, route-select enum (ROUTE_MAIN, ROUTE_DMEM).
- Sub-module rr_arbiter: parametric N-way round-robin; inputs request vector and pointer, outputs one-hot grant and index.
- The bridge holds the FSM, latches, timeout counter and routing.

Test Plan:
- Single read, N_PORTS=2: port 1 reads 0x0000_0010 while memory acks the next cycle with 0xDEADBEEF -> core_stb high 1 cycle, rsp_ack_o=2'b10 two cycles after request, rsp_rdata_o=0xDEADBEEF.
- Contention: both ports request continuously from reset -> grants alternate 0,1,0,1 over 4 transactions; never two consecutive grants to the same port.
- Routing, SECOND_MEM_EN=1: writes to 0x8000_0004 (wstrb 4'b0011) and 0x0000_0004 -> first appears only on data_mem_*, second only on core_*, each with wstrb preserved.
- Timeout, TIMEOUT_CYCLES=8: memory never acks -> stb held exactly 8 cycles, then rsp_err_o pulses for the requester with rdata=0, and the next request is served normally.
- Ack coincident with the timeout cycle -> rsp_ack_o pulses, rsp_err_o stays 0.
- Reset mid-BUSY: rst_n low for 1 cycle -> next edge cyc/stb=0, no ack/err pulse, pointer=0; a later stray core_ack is ignored.
